// File: rtl/eth_irq_pkg.sv
// Shared types for the Ethernet DMA interrupt coalescer.
// The state encoding is visible to software through the status register.
package eth_irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    FIRE    = 2'd2,
    HOLDOFF = 2'd3
  } eth_irq_state_e;

endpackage

// File: rtl/eth_irq_coalesce.sv
// Interrupt coalescer for one DMA direction: batches raw interrupt edges into one
// level interrupt, fired on an event-count threshold or on a timeout, with a hold-off after ack.
module eth_irq_coalesce
  import eth_irq_pkg::*;
#(
  parameter int CountWidth = 8,
  parameter int TimerWidth = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [CountWidth-1:0] count_thresh_i,
  input  logic [TimerWidth-1:0] timeout_i,
  input  logic [TimerWidth-1:0] holdoff_i,
  input  logic                  event_i,
  input  logic                  ack_i,
  output logic                  irq_o,
  output logic [CountWidth-1:0] pending_o,
  output logic [1:0]            state_o
);

  localparam logic [CountWidth-1:0] CountMax = '1;
  localparam logic [CountWidth-1:0] CountOne = CountWidth'(1);
  localparam logic [TimerWidth-1:0] TimerOne = TimerWidth'(1);

  eth_irq_state_e        state;
  logic [CountWidth-1:0] count;
  logic [TimerWidth-1:0] timer;
  logic                  event_q;
  logic                  irq_q;

  logic                  rise;
  logic [CountWidth-1:0] count_nxt;
  logic [CountWidth-1:0] rise_count;
  logic [CountWidth-1:0] thr_eff;
  logic [TimerWidth-1:0] timer_dec;
  logic                  timeout_hit;

  assign rise = event_i & ~event_q;

  // The timer is shared between timeout and hold-off; it parks at zero once expired.
  always_comb begin
    count_nxt   = count;
    rise_count  = '0;
    thr_eff     = count_thresh_i;
    timer_dec   = '0;
    timeout_hit = 1'b0;
    if (rise && (count != CountMax)) begin
      count_nxt = count + CountOne;
    end
    if (rise) begin
      rise_count = CountOne;
    end
    if (count_thresh_i == '0) begin
      thr_eff = CountOne;
    end
    if (timer != '0) begin
      timer_dec = timer - TimerOne;
    end
    timeout_hit = (timeout_i != '0) && (timer == TimerOne);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      count   <= '0;
      timer   <= '0;
      event_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      event_q <= event_i;
      if (!enable_i) begin
        state <= IDLE;
        count <= '0;
        timer <= '0;
        irq_q <= event_i;
      end else begin
        irq_q <= 1'b0;
        case (state)
          IDLE: begin
            if (rise) begin
              count <= CountOne;
              if (thr_eff == CountOne) begin
                state <= FIRE;
                irq_q <= 1'b1;
              end else begin
                state <= ARMED;
                timer <= timeout_i;
              end
            end
          end

          ARMED: begin
            count <= count_nxt;
            timer <= timer_dec;
            if ((count_nxt >= thr_eff) || timeout_hit) begin
              state <= FIRE;
              irq_q <= 1'b1;
            end
          end

          // An edge arriving together with the ack starts the next batch.
          FIRE: begin
            if (ack_i) begin
              count <= rise_count;
              if (holdoff_i != '0) begin
                state <= HOLDOFF;
                timer <= holdoff_i;
              end else if (rise) begin
                state <= ARMED;
                timer <= timeout_i;
              end else begin
                state <= IDLE;
              end
            end else begin
              count <= count_nxt;
              irq_q <= 1'b1;
            end
          end

          HOLDOFF: begin
            count <= count_nxt;
            timer <= timer_dec;
            if (timer == TimerOne) begin
              if (count_nxt == '0) begin
                state <= IDLE;
              end else begin
                state <= ARMED;
                timer <= timeout_i;
              end
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign irq_o     = irq_q;
  assign pending_o = count;
  assign state_o   = state;

endmodule

// File: tb/tb_eth_irq_coalesce.sv
// Directed bench for eth_irq_coalesce: a cycle-level reference model is compared every cycle,
// plus hand-derived checkpoints along the scenario.
module tb_eth_irq_coalesce;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic [7:0] thresh = 8'd4;
  logic [15:0] timeout = 16'd0;
  logic [15:0] holdoff = 16'd0;
  logic       ev = 1'b0;
  logic       ack = 1'b0;
  logic       irq_o;
  logic [7:0] pending_o;
  logic [1:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: absolute-cycle deadlines instead of a down-counter.
  int m_mode = 0;
  int m_pend = 0;
  bit m_irq  = 1'b0;
  bit m_prev = 1'b0;
  int cyc = 0;
  int deadline = 0;
  bit model_valid = 1'b0;

  eth_irq_coalesce #(.CountWidth(8), .TimerWidth(16)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .enable_i(enable),
    .count_thresh_i(thresh),
    .timeout_i(timeout),
    .holdoff_i(holdoff),
    .event_i(ev),
    .ack_i(ack),
    .irq_o(irq_o),
    .pending_o(pending_o),
    .state_o(state_o)
  );

  initial forever #5 clk = ~clk;

  initial begin : model
    int r;
    int np;
    int thr;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (rst) begin
        m_mode = 0;
        m_pend = 0;
        m_irq  = 1'b0;
        m_prev = 1'b0;
      end else begin
        r = (ev && !m_prev) ? 1 : 0;
        m_prev = ev;
        if (!enable) begin
          m_mode = 0;
          m_pend = 0;
          m_irq  = ev;
        end else begin
          thr = (thresh == 8'd0) ? 1 : int'(thresh);
          np = m_pend + r;
          if (np > 255) np = 255;
          if (m_mode == 0) begin
            if (r == 1) begin
              m_pend = 1;
              if (thr == 1) m_mode = 2;
              else begin
                m_mode = 1;
                deadline = cyc + int'(timeout);
              end
            end
          end else if (m_mode == 1) begin
            m_pend = np;
            if (np >= thr || (timeout != 16'd0 && cyc == deadline)) m_mode = 2;
          end else if (m_mode == 2) begin
            if (ack) begin
              m_pend = r;
              if (holdoff != 16'd0) begin
                m_mode = 3;
                deadline = cyc + int'(holdoff);
              end else if (r == 1) begin
                m_mode = 1;
                deadline = cyc + int'(timeout);
              end else begin
                m_mode = 0;
              end
            end else begin
              m_pend = np;
            end
          end else begin
            m_pend = np;
            if (cyc == deadline) begin
              if (np == 0) m_mode = 0;
              else begin
                m_mode = 1;
                deadline = cyc + int'(timeout);
              end
            end
          end
          m_irq = (m_mode == 2);
        end
      end
      model_valid = 1'b1;
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (model_valid) begin
        n_checks = n_checks + 3;
        if (irq_o !== m_irq) begin
          n_fail = n_fail + 1;
          $display("[TB] FAIL model_irq cycle %0d: got %0b expected %0b", cyc, irq_o, m_irq);
        end
        if (pending_o !== 8'(m_pend)) begin
          n_fail = n_fail + 1;
          $display("[TB] FAIL model_pending cycle %0d: got %0d expected %0d", cyc, pending_o, m_pend);
        end
        if (state_o !== 2'(m_mode)) begin
          n_fail = n_fail + 1;
          $display("[TB] FAIL model_state cycle %0d: got %0d expected %0d", cyc, state_o, m_mode);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int gap);
    ev = 1'b1;
    cycles(1);
    ev = 1'b0;
    cycles(gap);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    cycles(1);
    ack = 1'b0;
  endtask

  task automatic check_lit(input string name, input int act, input int exp);
    n_checks = n_checks + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    cycles(3);
    rst = 1'b0;
    check_lit("reset_state", int'(state_o), 0);
    check_lit("reset_pending", int'(pending_o), 0);
    check_lit("reset_irq", int'(irq_o), 0);

    // Threshold of 4 events.
    for (int i = 0; i < 3; i++) pulse(2);
    check_lit("thr_armed_state", int'(state_o), 1);
    ev = 1'b1;
    cycles(1);
    ev = 1'b0;
    check_lit("thr_irq", int'(irq_o), 1);
    check_lit("thr_pending", int'(pending_o), 4);
    cycles(2);
    do_ack();
    check_lit("thr_ack_irq", int'(irq_o), 0);
    check_lit("thr_ack_pending", int'(pending_o), 0);
    check_lit("thr_ack_state", int'(state_o), 0);

    // Timeout of 100 cycles from a single event.
    thresh = 8'd8;
    timeout = 16'd100;
    pulse(0);
    check_lit("to_armed_state", int'(state_o), 1);
    check_lit("to_armed_pending", int'(pending_o), 1);
    cycles(99);
    check_lit("to_early_irq", int'(irq_o), 0);
    cycles(1);
    check_lit("to_fire_irq", int'(irq_o), 1);
    check_lit("to_fire_pending", int'(pending_o), 1);
    do_ack();
    check_lit("to_ack_state", int'(state_o), 0);

    // Hold-off of 50 cycles with an event during the gap.
    thresh = 8'd1;
    timeout = 16'd0;
    holdoff = 16'd50;
    pulse(0);
    check_lit("ho_fire_irq", int'(irq_o), 1);
    cycles(1);
    do_ack();
    check_lit("ho_enter_state", int'(state_o), 3);
    cycles(4);
    pulse(0);
    cycles(44);
    check_lit("ho_gap_irq", int'(irq_o), 0);
    check_lit("ho_gap_pending", int'(pending_o), 1);
    cycles(1);
    check_lit("ho_exit_state", int'(state_o), 1);
    cycles(1);
    check_lit("ho_refire_irq", int'(irq_o), 1);
    holdoff = 16'd0;
    do_ack();

    // Ack coincident with a new edge, without and with hold-off.
    pulse(1);
    ack = 1'b1;
    ev = 1'b1;
    cycles(1);
    ack = 1'b0;
    ev = 1'b0;
    check_lit("ackev_pending", int'(pending_o), 1);
    check_lit("ackev_state", int'(state_o), 1);
    cycles(1);
    check_lit("ackev_refire", int'(irq_o), 1);
    holdoff = 16'd10;
    cycles(1);
    ack = 1'b1;
    ev = 1'b1;
    cycles(1);
    ack = 1'b0;
    ev = 1'b0;
    check_lit("ackev_ho_state", int'(state_o), 3);
    check_lit("ackev_ho_pending", int'(pending_o), 1);
    cycles(12);
    holdoff = 16'd0;
    do_ack();

    // Lowering the threshold while armed fires on the next cycle.
    thresh = 8'd8;
    for (int i = 0; i < 3; i++) pulse(1);
    check_lit("thrchg_pending", int'(pending_o), 3);
    thresh = 8'd2;
    cycles(1);
    check_lit("thrchg_state", int'(state_o), 2);
    do_ack();

    // Saturation with threshold 0 (acts as 1) and 255.
    thresh = 8'd0;
    for (int i = 0; i < 300; i++) pulse(1);
    check_lit("sat0_pending", int'(pending_o), 255);
    do_ack();
    check_lit("sat0_ack_pending", int'(pending_o), 0);
    thresh = 8'd255;
    for (int i = 0; i < 254; i++) pulse(1);
    check_lit("sat255_pre_irq", int'(irq_o), 0);
    check_lit("sat255_pre_pending", int'(pending_o), 254);
    for (int i = 0; i < 46; i++) pulse(1);
    check_lit("sat255_irq", int'(irq_o), 1);
    check_lit("sat255_pending", int'(pending_o), 255);
    do_ack();

    // A level held high counts once.
    thresh = 8'd8;
    ev = 1'b1;
    cycles(20);
    check_lit("level_pending", int'(pending_o), 1);
    ev = 1'b0;
    cycles(2);

    // Bypass mode.
    enable = 1'b0;
    cycles(1);
    check_lit("byp_state", int'(state_o), 0);
    check_lit("byp_pending", int'(pending_o), 0);
    ev = 1'b1;
    cycles(1);
    check_lit("byp_irq_high", int'(irq_o), 1);
    ev = 1'b0;
    ack = 1'b1;
    cycles(1);
    ack = 1'b0;
    check_lit("byp_irq_low", int'(irq_o), 0);
    ev = 1'b1;
    cycles(2);
    enable = 1'b1;
    cycles(3);
    check_lit("reenable_pending", int'(pending_o), 0);
    check_lit("reenable_irq", int'(irq_o), 0);
    ev = 1'b0;
    cycles(2);

    // Reset while firing.
    thresh = 8'd1;
    pulse(1);
    check_lit("rst_pre_irq", int'(irq_o), 1);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check_lit("rst_irq", int'(irq_o), 0);
    check_lit("rst_state", int'(state_o), 0);
    check_lit("rst_pending", int'(pending_o), 0);
    cycles(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
